// File: rtl/ccff_loader_pkg.sv
// Shared types and CRC constants for the configuration-chain loader.
// crc16_step advances a CRC-16-CCITT register by one serial bit, MSB first.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic feedback;
        feedback = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (feedback ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator: clear reloads the init value,
// en absorbs bit_in, otherwise the signature holds.
module ccff_crc16_serial
    import ccff_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] crc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_reg <= CRC_INIT;
        end else if (clear) begin
            crc_reg <= CRC_INIT;
        end else if (en) begin
            crc_reg <= crc16_step(crc_reg, bit_in);
        end
    end

    assign crc = crc_reg;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises bitstream words MSB first onto a configuration DFF chain,
// counting exactly CHAIN_LEN shifts and signing both loaded and readback bits.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 32,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              chain_clk_en,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [CNT_W-1:0]  bit_count,
    output logic [15:0]       load_crc,
    output logic [15:0]       readback_crc
);

    localparam int SC_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);

    state_e            state_reg, state_next;
    logic [WORD_W-1:0] sr_reg, sr_next;
    logic [WORD_W-1:0] hr_reg, hr_next;
    logic [SC_W-1:0]   sr_cnt_reg, sr_cnt_next;
    logic              hr_full_reg, hr_full_next;
    logic [CNT_W-1:0]  bit_count_reg, bit_count_next;
    logic              aborted_reg, aborted_next;

    logic in_load, sr_empty, head_bit, shift_en, last_shift, crc_clear, accept;

    // An empty SR is transparently backed by HR so a waiting word shifts with no bubble.
    always_comb begin
        in_load    = (state_reg == LOAD);
        sr_empty   = (sr_cnt_reg == '0);
        head_bit   = sr_empty ? hr_reg[WORD_W-1] : sr_reg[WORD_W-1];
        shift_en   = in_load && !abort && (!sr_empty || hr_full_reg);
        last_shift = shift_en && (bit_count_reg == LAST_SHIFT);
        crc_clear  = (state_reg == IDLE) && start;
        accept     = cfg_valid && in_load && !hr_full_reg;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = LOAD;
            LOAD: begin
                if (abort)           state_next = IDLE;
                else if (last_shift) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sr_next        = sr_reg;
        sr_cnt_next    = sr_cnt_reg;
        hr_next        = hr_reg;
        hr_full_next   = hr_full_reg;
        bit_count_next = bit_count_reg;
        aborted_next   = in_load && abort;

        if (shift_en) begin
            bit_count_next = bit_count_reg + CNT_W'(1);
            if (sr_empty) begin
                sr_next      = hr_reg << 1;
                sr_cnt_next  = SC_W'(WORD_W - 1);
                hr_full_next = 1'b0;
            end else begin
                sr_next     = sr_reg << 1;
                sr_cnt_next = sr_cnt_reg - SC_W'(1);
            end
        end

        if (accept) begin
            hr_next      = cfg_data;
            hr_full_next = 1'b1;
        end

        // Leftover bits past the chain end, or of an aborted load, are dropped.
        if ((in_load && abort) || last_shift) begin
            sr_next      = '0;
            sr_cnt_next  = '0;
            hr_next      = '0;
            hr_full_next = 1'b0;
        end

        if (crc_clear) bit_count_next = '0;
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state_reg     <= IDLE;
            sr_reg        <= '0;
            sr_cnt_reg    <= '0;
            hr_reg        <= '0;
            hr_full_reg   <= 1'b0;
            bit_count_reg <= '0;
            aborted_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sr_reg        <= sr_next;
            sr_cnt_reg    <= sr_cnt_next;
            hr_reg        <= hr_next;
            hr_full_reg   <= hr_full_next;
            bit_count_reg <= bit_count_next;
            aborted_reg   <= aborted_next;
        end
    end

    // Lane 0 signs the bits driven into the chain, lane 1 the bits coming out.
    logic [1:0]  crc_bit;
    logic [15:0] crc_val [2];

    assign crc_bit = {ccff_tail, head_bit};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_crc
            ccff_crc16_serial u_crc (
                .clk    (prog_clk),
                .rst_n  (prog_rst_n),
                .clear  (crc_clear),
                .en     (shift_en),
                .bit_in (crc_bit[gi]),
                .crc    (crc_val[gi])
            );
        end
    endgenerate

    assign cfg_ready    = in_load && !hr_full_reg;
    assign chain_clk_en = shift_en;
    assign ccff_head    = shift_en && head_bit;
    assign busy         = in_load;
    assign done         = (state_reg == DONE);
    assign aborted      = aborted_reg;
    assign bit_count    = bit_count_reg;
    assign load_crc     = crc_val[0];
    assign readback_crc = crc_val[1];

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: two instances (64- and 40-DFF chains), each
// driving a behavioural chain model, checked against bit-list and CRC references.
module tb_ccff_chain_loader;

    localparam int LA = 64;
    localparam int LB = 40;
    localparam int W  = 32;
    localparam int CA = $clog2(LA + 1);
    localparam int CB = $clog2(LB + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Instance A: 64-bit chain
    logic          start, abort, cfg_valid, cfg_ready, ccff_head, ccff_tail;
    logic          chain_clk_en, busy, done, aborted;
    logic [W-1:0]  cfg_data;
    logic [CA-1:0] bit_count;
    logic [15:0]   load_crc, readback_crc;
    logic [LA-1:0] chain_a = '0;

    ccff_chain_loader #(.CHAIN_LEN(LA), .WORD_W(W)) u_dut_a (
        .prog_clk(clk), .prog_rst_n(rst_n), .start(start), .abort(abort),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .ccff_head(ccff_head), .ccff_tail(ccff_tail), .chain_clk_en(chain_clk_en),
        .busy(busy), .done(done), .aborted(aborted), .bit_count(bit_count),
        .load_crc(load_crc), .readback_crc(readback_crc)
    );

    assign ccff_tail = chain_a[LA-1];
    always @(posedge clk) if (chain_clk_en) chain_a <= {chain_a[LA-2:0], ccff_head};

    // Instance B: 40-bit chain
    logic          b_start, b_abort, b_cfg_valid, b_cfg_ready, b_head, b_tail;
    logic          b_en, b_busy, b_done, b_aborted;
    logic [W-1:0]  b_cfg_data;
    logic [CB-1:0] b_bit_count;
    logic [15:0]   b_load_crc, b_readback_crc;
    logic [LB-1:0] chain_b = '0;

    ccff_chain_loader #(.CHAIN_LEN(LB), .WORD_W(W)) u_dut_b (
        .prog_clk(clk), .prog_rst_n(rst_n), .start(b_start), .abort(b_abort),
        .cfg_data(b_cfg_data), .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready),
        .ccff_head(b_head), .ccff_tail(b_tail), .chain_clk_en(b_en),
        .busy(b_busy), .done(b_done), .aborted(b_aborted), .bit_count(b_bit_count),
        .load_crc(b_load_crc), .readback_crc(b_readback_crc)
    );

    assign b_tail = chain_b[LB-1];
    always @(posedge clk) if (b_en) chain_b <= {chain_b[LB-2:0], b_head};

    int checks = 0;
    int errors = 0;

    // Reference CRC-16-CCITT over bits[n-1] down to bits[0], first bit = bits[n-1].
    function automatic logic [15:0] crc_bits(input logic [127:0] bits, input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = n - 1; i >= 0; i--) begin
            if (c[15] ^ bits[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // Results of the most recent drive_stream run on instance A
    int          r_en_cnt, r_first_en, r_last_en, r_done_cnt, r_done_cyc, r_abort_cnt, r_accept0;
    bit          r_busy_at_done, r_ready_after_end, r_timeout;
    logic [63:0] r_prior;

    // Runs one load on A: word 1 offered at once, word 2 offered 'hold' cycles after
    // word 1 is accepted; optional one-cycle abort once bit_count reaches abort_at.
    task automatic drive_stream(input logic [31:0] w0, input logic [31:0] w1,
                                input int hold, input int abort_at);
        int cyc, widx, tail_left;
        bit abort_sent, ended;
        r_en_cnt = 0; r_first_en = -1; r_last_en = -1; r_done_cnt = 0; r_done_cyc = -1;
        r_abort_cnt = 0; r_accept0 = -1; r_busy_at_done = 1'b1; r_ready_after_end = 1'b0;
        r_timeout = 1'b1;
        r_prior = chain_a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; widx = 0; tail_left = 3; abort_sent = 1'b0; ended = 1'b0;
        while (cyc < 300) begin
            if (done) begin r_done_cnt++; r_done_cyc = cyc; r_busy_at_done = busy; end
            if (aborted) r_abort_cnt++;
            if (ended && cfg_ready) r_ready_after_end = 1'b1;
            if (done || aborted) ended = 1'b1;
            if (ended) begin
                if (tail_left == 0) begin r_timeout = 1'b0; break; end
                tail_left--;
            end
            abort = 1'b0;
            if (abort_at >= 0 && !abort_sent && busy && int'(bit_count) == abort_at) begin
                abort = 1'b1; abort_sent = 1'b1;
            end
            cfg_valid = 1'b0;
            cfg_data  = $urandom;
            if (widx == 0) begin
                cfg_valid = 1'b1; cfg_data = w0;
            end else if (widx == 1 && cyc >= r_accept0 + hold) begin
                cfg_valid = 1'b1; cfg_data = w1;
            end
            #1;
            if (chain_clk_en) begin
                r_en_cnt++;
                if (r_first_en < 0) r_first_en = cyc;
                r_last_en = cyc;
            end
            if (cfg_valid && cfg_ready && !abort) begin
                if (widx == 0) r_accept0 = cyc;
                widx++;
            end
            @(negedge clk);
            cyc++;
        end
        abort = 1'b0;
        cfg_valid = 1'b0;
        $display("load w0=%h w1=%h hold=%0d abort_at=%0d: en=%0d span=%0d done=%0d aborted=%0d bit_count=%0d",
                 w0, w1, hold, abort_at, r_en_cnt, r_last_en - r_first_en + 1, r_done_cnt,
                 r_abort_cnt, bit_count);
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        #12;
        checks++; if (cfg_ready !== 1'b0)    begin errors++; $display("FAIL reset_ready: got %b want 0", cfg_ready); end
        checks++; if (ccff_head !== 1'b0)    begin errors++; $display("FAIL reset_head: got %b want 0", ccff_head); end
        checks++; if (chain_clk_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", chain_clk_en); end
        checks++; if ({busy, done, aborted} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, done, aborted}); end
        checks++; if (bit_count !== '0)      begin errors++; $display("FAIL reset_count: got %0d want 0", bit_count); end
        checks++; if (load_crc !== 16'hFFFF || readback_crc !== 16'hFFFF) begin
            errors++; $display("FAIL reset_crc: got %h/%h want ffff/ffff", load_crc, readback_crc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1 || cfg_ready !== 1'b1) begin
            errors++; $display("FAIL start_latency: busy=%b ready=%b want 1/1", busy, cfg_ready);
        end
        cfg_valid = 1'b1; cfg_data = $urandom;
        @(negedge clk);
        cfg_valid = 1'b0;
        n = 0;
        while (bit_count != 10 && n < 60) begin @(negedge clk); n++; end
        checks++; if (bit_count !== CA'(10)) begin errors++; $display("FAIL reach_10: got %0d want 10", bit_count); end
        rst_n = 1'b0;
        #1;
        checks++; if ({cfg_ready, ccff_head, chain_clk_en, busy, done, aborted} !== 6'b0 ||
                      bit_count !== '0 || load_crc !== 16'hFFFF || readback_crc !== 16'hFFFF) begin
            errors++;
            $display("FAIL midload_reset: ready=%b head=%b en=%b busy=%b count=%0d crc=%h/%h want all reset",
                     cfg_ready, ccff_head, chain_clk_en, busy, bit_count, load_crc, readback_crc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_stream($urandom, $urandom, 1, -1);
        checks++; if (r_timeout || r_done_cnt != 1) begin errors++; $display("FAIL reload_done: got %0d pulses (timeout=%b) want 1", r_done_cnt, r_timeout); end
        checks++; if (bit_count !== CA'(64)) begin errors++; $display("FAIL reload_count: got %0d want 64", bit_count); end
    endtask

    logic [15:0] crc_case2;

    task automatic test_back_to_back();
        logic [63:0] bits;
        bits = {32'hA5A5_0F0F, 32'h1234_5678};
        drive_stream(bits[63:32], bits[31:0], 1, -1);
        crc_case2 = crc_bits({64'd0, bits}, 64);
        checks++; if (r_en_cnt != 64 || r_last_en - r_first_en + 1 != 64) begin
            errors++; $display("FAIL b2b_en: count=%0d span=%0d want 64/64", r_en_cnt, r_last_en - r_first_en + 1);
        end
        checks++; if (r_first_en != r_accept0 + 1) begin errors++; $display("FAIL b2b_first_bit: at %0d want %0d", r_first_en, r_accept0 + 1); end
        checks++; if (r_done_cnt != 1 || r_done_cyc != r_last_en + 1 || r_busy_at_done) begin
            errors++; $display("FAIL b2b_done: pulses=%0d at %0d busy=%b want 1 at %0d busy=0",
                               r_done_cnt, r_done_cyc, r_busy_at_done, r_last_en + 1);
        end
        checks++; if (chain_a !== bits) begin errors++; $display("FAIL b2b_chain: got %h want %h", chain_a, bits); end
        checks++; if (load_crc !== crc_case2) begin errors++; $display("FAIL b2b_load_crc: got %h want %h", load_crc, crc_case2); end
        checks++; if (readback_crc !== crc_bits({64'd0, r_prior}, 64)) begin
            errors++; $display("FAIL b2b_readback: got %h want %h", readback_crc, crc_bits({64'd0, r_prior}, 64));
        end
        checks++; if (r_ready_after_end) begin errors++; $display("FAIL b2b_ready_after_done: got 1 want 0"); end
    endtask

    task automatic test_readback();
        drive_stream(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, -1);
        checks++; if (readback_crc !== crc_case2) begin errors++; $display("FAIL readback_crc: got %h want %h", readback_crc, crc_case2); end
        checks++; if (chain_a !== {64{1'b1}}) begin errors++; $display("FAIL readback_chain: got %h want all ones", chain_a); end
    endtask

    task automatic test_starved();
        logic [63:0] bits;
        bits = {32'hA5A5_0F0F, 32'h1234_5678};
        drive_stream(bits[63:32], bits[31:0], 37, -1);
        checks++; if (r_en_cnt != 64 || r_last_en - r_first_en + 1 != 69) begin
            errors++; $display("FAIL starved_en: count=%0d span=%0d want 64/69", r_en_cnt, r_last_en - r_first_en + 1);
        end
        checks++; if (chain_a !== bits || load_crc !== crc_case2 || bit_count !== CA'(64)) begin
            errors++; $display("FAIL starved_final: chain=%h crc=%h count=%0d want %h %h 64", chain_a, load_crc, bit_count, bits, crc_case2);
        end
    endtask

    task automatic test_random();
        logic [63:0] bits;
        int hold, gap;
        for (int k = 0; k < 4; k++) begin
            bits = {$urandom, $urandom};
            hold = $urandom_range(1, 45);
            gap  = (hold > 32) ? hold - 32 : 0;
            drive_stream(bits[63:32], bits[31:0], hold, -1);
            checks++; if (r_en_cnt != 64 || r_last_en - r_first_en + 1 != 64 + gap || r_done_cnt != 1) begin
                errors++; $display("FAIL rand_en[%0d]: count=%0d span=%0d done=%0d want 64/%0d/1",
                                   k, r_en_cnt, r_last_en - r_first_en + 1, r_done_cnt, 64 + gap);
            end
            checks++; if (chain_a !== bits) begin errors++; $display("FAIL rand_chain[%0d]: got %h want %h", k, chain_a, bits); end
            checks++; if (load_crc !== crc_bits({64'd0, bits}, 64) || readback_crc !== crc_bits({64'd0, r_prior}, 64)) begin
                errors++; $display("FAIL rand_crc[%0d]: got %h/%h want %h/%h", k, load_crc, readback_crc,
                                   crc_bits({64'd0, bits}, 64), crc_bits({64'd0, r_prior}, 64));
            end
        end
    endtask

    task automatic test_short_chain();
        logic [39:0] bits;
        logic [39:0] prior;
        int cyc, widx, en_cnt, done_cnt;
        bit ended, ready_after;
        bits  = {32'hDEADBEEF, 8'hCA};
        prior = chain_b;
        en_cnt = 0; done_cnt = 0; ended = 1'b0; ready_after = 1'b0; widx = 0;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (cyc = 1; cyc < 120; cyc++) begin
            if (ended && b_cfg_ready) ready_after = 1'b1;
            if (b_done) begin done_cnt++; ended = 1'b1; end
            b_cfg_valid = (widx < 2);
            b_cfg_data  = (widx == 0) ? 32'hDEADBEEF : 32'hCAFEBABE;
            #1;
            if (b_en) en_cnt++;
            if (b_cfg_valid && b_cfg_ready) widx++;
            @(negedge clk);
        end
        b_cfg_valid = 1'b0;
        $display("short load: en=%0d done=%0d bit_count=%0d chain=%h", en_cnt, done_cnt, b_bit_count, chain_b);
        checks++; if (en_cnt != 40 || done_cnt != 1 || b_bit_count !== CB'(40)) begin
            errors++; $display("FAIL short_count: en=%0d done=%0d count=%0d want 40/1/40", en_cnt, done_cnt, b_bit_count);
        end
        checks++; if (chain_b !== bits) begin errors++; $display("FAIL short_chain: got %h want %h", chain_b, bits); end
        checks++; if (ready_after) begin errors++; $display("FAIL short_ready_after_done: got 1 want 0"); end
        checks++; if (b_load_crc !== crc_bits({88'd0, bits}, 40) || b_readback_crc !== crc_bits({88'd0, prior}, 40)) begin
            errors++; $display("FAIL short_crc: got %h/%h want %h/%h", b_load_crc, b_readback_crc,
                               crc_bits({88'd0, bits}, 40), crc_bits({88'd0, prior}, 40));
        end
    endtask

    task automatic test_abort();
        logic [63:0] bits;
        bits = {$urandom, $urandom};
        drive_stream(bits[63:32], bits[31:0], 1, 17);
        checks++; if (r_abort_cnt != 1 || r_done_cnt != 0 || r_timeout) begin
            errors++; $display("FAIL abort_pulse: aborted=%0d done=%0d timeout=%b want 1/0/0", r_abort_cnt, r_done_cnt, r_timeout);
        end
        checks++; if (bit_count !== CA'(17) || busy !== 1'b0) begin errors++; $display("FAIL abort_hold: count=%0d busy=%b want 17/0", bit_count, busy); end
        checks++; if (load_crc !== crc_bits({64'd0, bits} >> 47, 17) || chain_a !== {r_prior[46:0], bits[63:47]}) begin
            errors++; $display("FAIL abort_state: crc=%h chain=%h want %h %h", load_crc, chain_a,
                               crc_bits({64'd0, bits} >> 47, 17), {r_prior[46:0], bits[63:47]});
        end
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b1 || aborted !== 1'b0 || bit_count !== '0) begin
            errors++; $display("FAIL start_beats_abort: busy=%b aborted=%b count=%0d want 1/0/0", busy, aborted, bit_count);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (aborted !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_empty_load: aborted=%b busy=%b want 1/0", aborted, busy); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (aborted !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_in_idle: aborted=%b busy=%b want 0/0", aborted, busy); end
    endtask

    initial begin
        start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        b_start = 1'b0; b_abort = 1'b0; b_cfg_valid = 1'b0; b_cfg_data = '0;
        test_reset();
        test_back_to_back();
        test_readback();
        test_starved();
        test_random();
        test_short_chain();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
